// File: rtl/apb_pwm_timer.sv
// APB3 timer/PWM peripheral: two 32-bit down-counters driving TIMEROUT and a maskable
// level interrupt, ticking on PCLK or on synchronised rising edges of EXTIN.
module apb_pwm_timer (
   input  logic        PCLK,
   input  logic        PRESETn,
   input  logic        PSEL,
   input  logic [9:0]  PADDR,
   input  logic        PENABLE,
   input  logic        PWRITE,
   input  logic [31:0] PWDATA,
   output logic [31:0] PRDATA,
   output logic        PREADY,
   output logic        PSLVERR,
   input  logic        EXTIN,
   output logic        TIMEROUT,
   output logic        TIMERINT
);

   localparam logic [9:0] ADDR_CTRL = 10'd0;
   localparam logic [9:0] ADDR_CUR0 = 10'd1;
   localparam logic [9:0] ADDR_RLD0 = 10'd2;
   localparam logic [9:0] ADDR_CUR1 = 10'd3;
   localparam logic [9:0] ADDR_RLD1 = 10'd4;
   localparam logic [9:0] ADDR_INT  = 10'd5;

   logic [5:0]  r_ctrl, w_ctrl_nxt;
   logic [31:0] r_cur0, w_cur0_nxt;
   logic [31:0] r_rld0, w_rld0_nxt;
   logic [31:0] r_cur1, w_cur1_nxt;
   logic [31:0] r_rld1, w_rld1_nxt;
   logic        r_flag, w_flag_nxt;
   logic        r_tout, w_tout_nxt;
   logic [2:0]  r_ext;  // [1:0] two-stage synchroniser, [2] previous synchronised level

   logic       w_wr, w_mapped, w_ext_rise, w_tick, w_zero;
   logic       w_oneshot, w_pwm, w_pulse;
   logic [2:0] w_mode;

   assign w_mode     = r_ctrl[3:1];
   assign w_oneshot  = (w_mode == 3'b000);
   assign w_pwm      = (w_mode == 3'b011);
   assign w_pulse    = (w_mode == 3'b100);
   assign w_ext_rise = r_ext[1] & ~r_ext[2];
   assign w_tick     = r_ctrl[0] & (r_ctrl[5] ? w_ext_rise : 1'b1);
   assign w_wr       = PSEL & PENABLE & PWRITE;
   assign w_mapped   = (PADDR <= ADDR_INT);

   assign PREADY   = 1'b1;
   assign PSLVERR  = PSEL & PENABLE & ~w_mapped;
   assign TIMEROUT = r_tout;
   assign TIMERINT = r_flag & r_ctrl[4];

   always_comb begin
      PRDATA = '0;
      if (PSEL && !PWRITE) begin
         case (PADDR)
            ADDR_CTRL: PRDATA = {26'd0, r_ctrl};
            ADDR_CUR0: PRDATA = r_cur0;
            ADDR_RLD0: PRDATA = r_rld0;
            ADDR_CUR1: PRDATA = r_cur1;
            ADDR_RLD1: PRDATA = r_rld1;
            ADDR_INT:  PRDATA = {31'd0, r_flag};
            default:   PRDATA = '0;
         endcase
      end
   end

   always_comb begin
      w_ctrl_nxt = r_ctrl;
      w_cur0_nxt = r_cur0;
      w_rld0_nxt = r_rld0;
      w_cur1_nxt = r_cur1;
      w_rld1_nxt = r_rld1;
      w_flag_nxt = r_flag;
      w_tout_nxt = r_tout;
      w_zero     = 1'b0;

      if (w_tick) begin
         if (w_pwm) begin
            if (r_cur1 == 32'd0) begin
               w_zero     = 1'b1;
               w_cur1_nxt = r_rld1;
            end else begin
               w_cur1_nxt = r_cur1 - 32'd1;
            end
         end else if (r_cur0 == 32'd0) begin
            w_zero = 1'b1;
            if (w_oneshot) w_ctrl_nxt[0] = 1'b0;  // one-shot parks at zero
            else           w_cur0_nxt    = r_rld0;
         end else begin
            w_cur0_nxt = r_cur0 - 32'd1;
         end
      end

      if (r_ctrl[0]) begin
         if (w_pwm)                 w_tout_nxt = (w_cur1_nxt <= r_rld0);
         else if (w_pulse)          w_tout_nxt = w_zero;
         else if (w_oneshot)        w_tout_nxt = w_tick ? ~w_zero : r_tout;
         else if (w_zero)           w_tout_nxt = ~r_tout;
      end

      // Bus writes override counting; CTRL writes can force the output level.
      if (w_wr) begin
         case (PADDR)
            ADDR_CTRL: begin
               w_ctrl_nxt = PWDATA[5:0];
               if (!PWDATA[0])                w_tout_nxt = 1'b0;
               else if (PWDATA[3:1] == 3'b000) w_tout_nxt = 1'b1;
            end
            ADDR_CUR0: w_cur0_nxt = PWDATA;
            ADDR_RLD0: w_rld0_nxt = PWDATA;
            ADDR_CUR1: w_cur1_nxt = PWDATA;
            ADDR_RLD1: w_rld1_nxt = PWDATA;
            ADDR_INT:  w_flag_nxt = 1'b0;
            default: ;
         endcase
      end

      if (w_zero) w_flag_nxt = 1'b1;
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         r_ctrl <= '0;
         r_cur0 <= '0;
         r_rld0 <= '0;
         r_cur1 <= '0;
         r_rld1 <= '0;
         r_flag <= 1'b0;
         r_tout <= 1'b0;
         r_ext  <= '0;
      end else begin
         r_ctrl <= w_ctrl_nxt;
         r_cur0 <= w_cur0_nxt;
         r_rld0 <= w_rld0_nxt;
         r_cur1 <= w_cur1_nxt;
         r_rld1 <= w_rld1_nxt;
         r_flag <= w_flag_nxt;
         r_tout <= w_tout_nxt;
         r_ext  <= {r_ext[1], r_ext[0], EXTIN};
      end
   end

endmodule

// File: tb/tb_apb_pwm_timer.sv
// Directed testbench for apb_pwm_timer: register access, pulse/PWM/one-shot modes,
// disable/resume and asynchronous reset.
module tb_apb_pwm_timer;

   logic        PCLK, PRESETn, PSEL, PENABLE, PWRITE, EXTIN;
   logic [9:0]  PADDR;
   logic [31:0] PWDATA, PRDATA;
   logic        PREADY, PSLVERR, TIMEROUT, TIMERINT;

   int total = 0;
   int bad   = 0;

   apb_pwm_timer dut (
      .PCLK     (PCLK),
      .PRESETn  (PRESETn),
      .PSEL     (PSEL),
      .PADDR    (PADDR),
      .PENABLE  (PENABLE),
      .PWRITE   (PWRITE),
      .PWDATA   (PWDATA),
      .PRDATA   (PRDATA),
      .PREADY   (PREADY),
      .PSLVERR  (PSLVERR),
      .EXTIN    (EXTIN),
      .TIMEROUT (TIMEROUT),
      .TIMERINT (TIMERINT)
   );

   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic apb_write(input logic [9:0] addr, input logic [31:0] data);
      @(posedge PCLK); #1;
      PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = addr; PWDATA = data;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      @(posedge PCLK); #1;
      PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
   endtask

   task automatic apb_read(input logic [9:0] addr, output logic [31:0] data, output logic err);
      @(posedge PCLK); #1;
      PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = addr;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      #1;
      data = PRDATA;
      err  = PSLVERR;
      @(posedge PCLK); #1;
      PSEL = 1'b0; PENABLE = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] rd;
      logic        er;
      PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
      PADDR = '0; PWDATA = '0; EXTIN = 1'b0;
      #12;
      total++; if (TIMEROUT !== 1'b0) begin bad++; $display("FAIL rst_tout got=%b exp=0", TIMEROUT); end
      total++; if (TIMERINT !== 1'b0) begin bad++; $display("FAIL rst_tint got=%b exp=0", TIMERINT); end
      total++; if (PSLVERR !== 1'b0) begin bad++; $display("FAIL rst_slverr got=%b exp=0", PSLVERR); end
      total++; if (PRDATA !== 32'h0) begin bad++; $display("FAIL rst_prdata got=%h exp=0", PRDATA); end
      total++; if (PREADY !== 1'b1) begin bad++; $display("FAIL rst_pready got=%b exp=1", PREADY); end
      @(negedge PCLK); PRESETn = 1'b1;
      apb_read(10'd0, rd, er);
      total++; if (rd !== 32'h0) begin bad++; $display("FAIL rst_ctrl got=%h exp=0", rd); end
      apb_read(10'd1, rd, er);
      total++; if (rd !== 32'h0) begin bad++; $display("FAIL rst_cur0 got=%h exp=0", rd); end
      apb_read(10'd2, rd, er);
      total++; if (rd !== 32'h0) begin bad++; $display("FAIL rst_rld0 got=%h exp=0", rd); end
   endtask

   task automatic test_regs();
      logic [31:0] rd;
      logic        er;
      apb_write(10'd1, 32'd9);
      apb_write(10'd2, 32'd9);
      apb_write(10'd3, 32'd19);
      apb_write(10'd4, 32'd19);
      apb_read(10'd1, rd, er);
      total++; if (rd !== 32'd9) begin bad++; $display("FAIL rb_cur0 got=%h exp=%h", rd, 32'd9); end
      apb_read(10'd2, rd, er);
      total++; if (rd !== 32'd9) begin bad++; $display("FAIL rb_rld0 got=%h exp=%h", rd, 32'd9); end
      apb_read(10'd3, rd, er);
      total++; if (rd !== 32'd19) begin bad++; $display("FAIL rb_cur1 got=%h exp=%h", rd, 32'd19); end
      apb_read(10'd4, rd, er);
      total++; if (rd !== 32'd19) begin bad++; $display("FAIL rb_rld1 got=%h exp=%h", rd, 32'd19); end
      apb_read(10'd7, rd, er);
      total++; if (er !== 1'b1) begin bad++; $display("FAIL unmapped_err got=%b exp=1", er); end
      total++; if (rd !== 32'h0) begin bad++; $display("FAIL unmapped_data got=%h exp=0", rd); end
      apb_write(10'd0, 32'hFFFF_FFC0);
      apb_read(10'd0, rd, er);
      total++; if (rd !== 32'h0) begin bad++; $display("FAIL ctrl_hi_bits got=%h exp=0", rd); end
   endtask

   task automatic test_pulse_extin();
      logic [31:0] rd;
      logic        er, prev;
      int          highs, dbl, ints, first_hi, second_hi;
      highs = 0; dbl = 0; ints = 0; first_hi = -1; second_hi = -1; prev = 1'b0;
      apb_write(10'd0, 32'h29);
      for (int k = 0; k < 90; k++) begin
         @(posedge PCLK); #1;
         EXTIN = (k % 2 == 0);
         if (TIMEROUT) begin
            highs++;
            if (prev) dbl++;
            if (first_hi < 0) first_hi = k;
            else if (second_hi < 0) second_hi = k;
         end
         if (TIMERINT) ints++;
         prev = TIMEROUT;
      end
      total++; if (highs !== 4) begin bad++; $display("FAIL pulse_count got=%0d exp=4", highs); end
      total++; if (dbl !== 0) begin bad++; $display("FAIL pulse_width got=%0d exp=0", dbl); end
      total++; if (second_hi - first_hi !== 20) begin
         bad++; $display("FAIL pulse_spacing got=%0d exp=20", second_hi - first_hi); end
      total++; if (ints !== 0) begin bad++; $display("FAIL pulse_tint got=%0d exp=0", ints); end
      apb_read(10'd5, rd, er);
      total++; if (rd !== 32'h1) begin bad++; $display("FAIL pulse_intflag got=%h exp=1", rd); end
      apb_read(10'd0, rd, er);
      total++; if (rd !== 32'h29) begin bad++; $display("FAIL pulse_ctrl got=%h exp=29", rd); end
   endtask

   task automatic test_pwm();
      logic prev;
      int   rise1, rise2, fall1, int_first, found;
      rise1 = -1; rise2 = -1; fall1 = -1; int_first = -1; found = 0;
      apb_write(10'd5, 32'h0);
      apb_write(10'd0, 32'h37);
      total++; if (TIMERINT !== 1'b0) begin bad++; $display("FAIL pwm_tint0 got=%b exp=0", TIMERINT); end
      prev = TIMEROUT;
      for (int k = 0; k < 100; k++) begin
         @(posedge PCLK); #1;
         EXTIN = (k % 2 == 0);
         if (TIMEROUT && !prev) begin
            if (rise1 < 0) rise1 = k;
            else if (rise2 < 0) rise2 = k;
         end
         if (!TIMEROUT && prev && fall1 < 0) fall1 = k;
         if (TIMERINT && int_first < 0) int_first = k;
         prev = TIMEROUT;
      end
      total++; if (rise2 - rise1 !== 40) begin
         bad++; $display("FAIL pwm_period got=%0d exp=40", rise2 - rise1); end
      total++; if (fall1 - rise1 !== 20) begin
         bad++; $display("FAIL pwm_high got=%0d exp=20", fall1 - rise1); end
      total++; if (int_first !== fall1 || int_first < 0) begin
         bad++; $display("FAIL pwm_int_at_wrap got=%0d exp=%0d", int_first, fall1); end
      apb_write(10'd5, 32'h0);
      total++; if (TIMERINT !== 1'b0) begin bad++; $display("FAIL pwm_int_clr got=%b exp=0", TIMERINT); end
      for (int k = 0; k < 60 && found == 0; k++) begin
         @(posedge PCLK); #1;
         EXTIN = (k % 2 == 0);
         if (TIMERINT) found = 1;
      end
      total++; if (found !== 1) begin bad++; $display("FAIL pwm_int_rearm got=%0d exp=1", found); end
      EXTIN = 1'b0;
   endtask

   task automatic test_oneshot();
      logic [31:0] rd;
      logic        er;
      int          hi;
      apb_write(10'd0, 32'h0);
      apb_write(10'd5, 32'h0);
      apb_write(10'd1, 32'd9);
      apb_write(10'd0, 32'h11);
      hi = TIMEROUT ? 1 : 0;
      for (int k = 1; k < 15; k++) begin
         @(posedge PCLK); #1;
         if (TIMEROUT) hi++;
      end
      total++; if (hi !== 10) begin bad++; $display("FAIL os_high got=%0d exp=10", hi); end
      total++; if (TIMEROUT !== 1'b0) begin bad++; $display("FAIL os_end got=%b exp=0", TIMEROUT); end
      total++; if (TIMERINT !== 1'b1) begin bad++; $display("FAIL os_tint got=%b exp=1", TIMERINT); end
      apb_read(10'd0, rd, er);
      total++; if (rd !== 32'h10) begin bad++; $display("FAIL os_ctrl got=%h exp=10", rd); end
      apb_read(10'd1, rd, er);
      total++; if (rd !== 32'h0) begin bad++; $display("FAIL os_cur0 got=%h exp=0", rd); end
   endtask

   task automatic test_disable();
      logic [31:0] rd;
      logic        er;
      apb_write(10'd0, 32'h0);
      apb_write(10'd3, 32'd11);
      apb_write(10'd0, 32'h07);
      apb_write(10'd0, 32'h0);  // three PCLK ticks elapse before this commits
      total++; if (TIMEROUT !== 1'b0) begin bad++; $display("FAIL dis_tout got=%b exp=0", TIMEROUT); end
      apb_read(10'd3, rd, er);
      total++; if (rd !== 32'd8) begin bad++; $display("FAIL dis_cur1 got=%0d exp=8", rd); end
      repeat (10) @(posedge PCLK);
      apb_read(10'd3, rd, er);
      total++; if (rd !== 32'd8) begin bad++; $display("FAIL dis_hold got=%0d exp=8", rd); end
      apb_write(10'd0, 32'h07);
      apb_read(10'd3, rd, er);
      total++; if (rd !== 32'd6) begin bad++; $display("FAIL resume_cur1 got=%0d exp=6", rd); end
      total++; if (TIMEROUT !== 1'b1) begin bad++; $display("FAIL resume_tout got=%b exp=1", TIMEROUT); end
   endtask

   task automatic test_async_reset();
      logic [31:0] rd;
      logic        er;
      apb_write(10'd0, 32'h17);
      total++; if (TIMERINT !== 1'b1) begin bad++; $display("FAIL persist_tint got=%b exp=1", TIMERINT); end
      @(posedge PCLK); #2;
      PRESETn = 1'b0;
      #1;
      total++; if (TIMERINT !== 1'b0) begin bad++; $display("FAIL arst_tint got=%b exp=0", TIMERINT); end
      total++; if (TIMEROUT !== 1'b0) begin bad++; $display("FAIL arst_tout got=%b exp=0", TIMEROUT); end
      @(negedge PCLK); PRESETn = 1'b1;
      apb_read(10'd0, rd, er);
      total++; if (rd !== 32'h0) begin bad++; $display("FAIL arst_ctrl got=%h exp=0", rd); end
      apb_read(10'd3, rd, er);
      total++; if (rd !== 32'h0) begin bad++; $display("FAIL arst_cur1 got=%h exp=0", rd); end
   endtask

   initial begin
      test_reset();
      test_regs();
      test_pulse_extin();
      test_pwm();
      test_oneshot();
      test_disable();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
